mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory and MMIO controller sitting directly downstream of the CPU memory port, consuming its address/read/write requests and returning read data. It holds a synchronous-read word RAM for instructions and data, plus a small MMIO window. The MMIO window provides an LED register, a free-running cycle counter, synchronized switch inputs, and a 4-deep byte TX FIFO drained over a valid/ready handshake.

## Interface
Parameters:
- RAM_WORDS, 4096: number of 16-bit RAM words; RAM occupies byte addresses 0 .. 2*RAM_WORDS-1.
- MMIO_BASE, 16'hF000: byte base address of the MMIO window.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_mem_addr  in  16  byte address from CPU; bit 0 ignored (word access only).
- i_mem_rd  in  1  read request.
- i_mem_wr  in  1  write request.
- i_mem_wrdata  in  16  write data.
- o_mem_rddata  out  16  registered read data.
- o_led  out  16  LED register contents.
- i_sw  in  16  asynchronous switch inputs.
- o_tx_valid  out  1  TX FIFO non-empty.
- o_tx_data  out  8  TX FIFO head byte.
- i_tx_ready  in  1  consumer accepts head byte when high with o_tx_valid.

## Operation
- Word index is i_mem_addr[15:1].
- RAM hit: addr < 2*RAM_WORDS.
- MMIO hit: addr[15:4] == MMIO_BASE[15:4].
- Any other address is unmapped.
- MMIO map (offset from MMIO_BASE):
  - 0x0 LED: R/W, 16 bits.
  - 0x2 CYCLE: RO; 16-bit counter, +1 every clk, wraps FFFF->0000.
  - 0x4 SW: RO; i_sw passed through a 2-flop synchronizer.
  - 0x6 TXDATA: WO; a write pushes i_mem_wrdata[7:0]. Reads return 0.
  - 0x8 STATUS: bit0 full, bit1 empty, bit2 overflow (sticky), bits[5:3] count (0..4), other bits 0. A write with wrdata[2]=1 clears overflow; other bits are ignored.
- Writes to RO registers, unused MMIO offsets, or unmapped addresses are ignored.
- Reads of unmapped or unused locations return 16'h0000.
- RAM:
  - Single port.
  - A write with i_mem_wr stores the word at the end of the cycle.
  - Simultaneous read and write to the same word returns the old data (read-before-write).
  - RAM contents are not reset.
- TX FIFO: 4 entries, circular, 2-bit read/write pointers plus a 3-bit count.
  - Pop occurs when o_tx_valid && i_tx_ready.
  - A push is accepted if count < 4, or if a pop occurs in the same cycle.
  - An otherwise-full push is dropped and sets overflow.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap 3 -> 0.
  - o_tx_data is the head entry. It reads 0 when empty.
- Overflow clear and a new overflow in the same cycle: the overflow bit ends up set.

## Timing
- Read latency is 1 cycle:
  - o_mem_rddata updates on the rising edge after a cycle with i_mem_rd=1.
  - It holds its value while i_mem_rd=0.
- MMIO reads sample register state before that edge's updates:
  - CYCLE returns the pre-increment value.
  - STATUS returns the pre-push/pop value.
- Write effects are visible to a read issued in the next cycle.
- Write and read to the same MMIO register in one cycle: the read returns the old value.
- SW latency is 2 cycles of synchronization, then 1 read cycle.
- A pushed byte appears on o_tx_valid/o_tx_data the cycle after the push, including when the FIFO was empty.
- Reset (reset=0), effective immediately and asynchronously:
  - Outputs: o_mem_rddata=0, o_led=0, o_tx_valid=0, o_tx_data=0.
  - Internal state: CYCLE=0, FIFO pointers and count=0, overflow=0, synchronizer flops=0.
- Reset mid-operation discards FIFO contents and any in-flight read. RAM is unaffected.
- After reset release, the first rising edge performs normal operation and CYCLE becomes 1.

## Test plan
- RAM write/read:
  - Stimulus: write 16'hBEEF at addr 0x0010; read 0x0010 and 0x0011 on consecutive cycles.
  - Required: o_mem_rddata=BEEF on each following cycle.
  - Also: write 16'h1234 to 0x0010 with a concurrent read of 0x0010; the read returns BEEF, and a later read returns 1234.
- MMIO map:
  - Stimulus: write 16'h00A5 to 0xF000.
  - Required: o_led=00A5 one cycle later; reading 0xF000 returns 00A5.
  - Stimulus: a write to 0xF002.
  - Required: CYCLE is unchanged.
  - Stimulus: read unmapped 0x9000.
  - Required: 0000.
- Cycle counter:
  - Stimulus: read 0xF002 N cycles after reset release.
  - Required: N; wrap from FFFF to 0000 verified after 65536 cycles.
- FIFO fill/overflow:
  - Stimulus: with i_tx_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55.
  - Required:
    - STATUS = full=1, count=4, overflow=1, i.e. 16'h0025.
    - Then i_tx_ready=1 drains 11, 22, 33, 44 in order, one per cycle, after which o_tx_valid=0.
    - Writing 0x0004 to STATUS clears overflow.
- FIFO simultaneous push/pop:
  - Stimulus: FIFO full, i_tx_ready=1, push 0x66 in the same cycle.
  - Required: count stays 4, overflow stays 0, and 0x66 emerges 4th.
- Async reset:
  - Stimulus: assert reset=0 mid-drain with 3 entries queued, between clock edges.
  - Required: o_tx_valid, o_led, and o_mem_rddata go to 0 immediately.
  - After release, STATUS reads empty=1 (16'h0002), and RAM data written earlier is still readable.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory and MMIO controller downstream of the CPU memory port.
// Holds a synchronous-read 16-bit word RAM and a small MMIO window with an
// LED register, free-running cycle counter, synchronized switches and a
// 4-deep byte TX FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk           single clock, rising edge
//   reset         asynchronous active-low reset
//   i_mem_addr    byte address (bit 0 ignored, word access only)
//   i_mem_rd      read request; data returned on o_mem_rddata next edge
//   i_mem_wr      write request
//   i_mem_wrdata  write data
//   o_mem_rddata  registered read data, holds while no read is issued
//   o_led         LED register
//   i_sw          asynchronous switch inputs
//   o_tx_valid    TX FIFO non-empty
//   o_tx_data     TX FIFO head byte (0 when empty)
//   i_tx_ready    consumer accepts the head byte when high with o_tx_valid
module mem_ctrl #(
  parameter int          RAM_WORDS = 4096,
  parameter logic [15:0] MMIO_BASE = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic [15:0] o_mem_rddata,
  output logic [15:0] o_led,
  input  logic [15:0] i_sw,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_CYCLE  = 4'h2;
  localparam logic [3:0] OFF_SW     = 4'h4;
  localparam logic [3:0] OFF_TXDATA = 4'h6;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  // Address decode
  logic          ram_hit;
  logic          mmio_hit;
  logic [3:0]    off;
  logic [AW-1:0] ram_idx;
  logic          addr_unused;

  assign ram_hit     = ({17'b0, i_mem_addr[15:1]} < RAM_LIMIT);
  // RAM takes priority should a large RAM ever overlap the MMIO window
  assign mmio_hit    = !ram_hit && (i_mem_addr[15:4] == MMIO_BASE[15:4]);
  assign off         = {i_mem_addr[3:1], 1'b0};
  assign ram_idx     = i_mem_addr[AW:1];
  assign addr_unused = i_mem_addr[0];

  // State
  logic [15:0] ram [RAM_WORDS];
  logic [7:0]  fifo_q [4];
  logic [15:0] rddata_q, rddata_d;
  logic [15:0] led_q, led_d;
  logic [15:0] cycle_q;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic        tx_valid;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic        ovf_clr;
  logic [15:0] status;

  assign tx_valid = (count_q != 3'd0);
  assign pop      = tx_valid && i_tx_ready;
  assign push_req = i_mem_wr && mmio_hit && (off == OFF_TXDATA);
  // When full, a simultaneous pop frees the head slot, which is exactly
  // the slot wr_ptr points at, so the push can land there.
  assign push_ok  = push_req && ((count_q != 3'd4) || pop);
  assign ovf_clr  = i_mem_wr && mmio_hit && (off == OFF_STATUS) && i_mem_wrdata[2];
  assign status   = {10'b0, count_q, ovf_q, (count_q == 3'd0), (count_q == 3'd4)};

  // Read mux samples pre-edge state of every register
  always_comb begin
    rddata_d = rddata_q;
    if (i_mem_rd) begin
      rddata_d = '0;
      if (ram_hit) begin
        rddata_d = ram[ram_idx];
      end else if (mmio_hit) begin
        case (off)
          OFF_LED:    rddata_d = led_q;
          OFF_CYCLE:  rddata_d = cycle_q;
          OFF_SW:     rddata_d = sw_sync_q;
          OFF_STATUS: rddata_d = status;
          default:    rddata_d = '0;
        endcase
      end
    end
  end

  always_comb begin
    led_d    = led_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (i_mem_wr && mmio_hit && (off == OFF_LED)) begin
      led_d = i_mem_wrdata;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    // Clear first so a same-cycle overflow wins
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rddata_q  <= '0;
      led_q     <= '0;
      cycle_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rddata_q  <= rddata_d;
      led_q     <= led_d;
      cycle_q   <= cycle_q + 16'd1;
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays carry no reset; RAM survives reset by design
  always_ff @(posedge clk) begin
    if (i_mem_wr && ram_hit) begin
      ram[ram_idx] <= i_mem_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= i_mem_wrdata[7:0];
    end
  end

  assign o_mem_rddata = rddata_q;
  assign o_led        = led_q;
  assign o_tx_valid   = tx_valid;
  assign o_tx_data    = tx_valid ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int RAM_WORDS = 4096;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wrdata;
  logic [15:0] mem_rddata;
  logic [15:0] led;
  logic [15:0] sw;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  mem_ctrl #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(16'hF000)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mem_addr   (mem_addr),
    .i_mem_rd     (mem_rd),
    .i_mem_wr     (mem_wr),
    .i_mem_wrdata (mem_wrdata),
    .o_mem_rddata (mem_rddata),
    .o_led        (led),
    .i_sw         (sw),
    .o_tx_valid   (tx_valid),
    .o_tx_data    (tx_data),
    .i_tx_ready   (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nassert = 0;
  int nfail   = 0;

  // Reference model state
  logic [15:0] mram [int];
  logic [7:0]  mq [$];
  logic [15:0] swh [$];
  logic [15:0] mled;
  logic [15:0] mcycle;
  logic        movf;
  logic [15:0] exp_rd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    swh.delete();
    swh.push_back(16'h0);
    swh.push_back(16'h0);
    mled   = 16'h0;
    mcycle = 16'h0;
    movf   = 1'b0;
    exp_rd = 16'h0;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai < 2 * RAM_WORDS) return mram[ai / 2];
    if (ai >= 'hF000 && ai <= 'hF00F) begin
      case ((ai - 'hF000) / 2)
        0: return mled;
        1: return mcycle;
        2: return swh[0];
        4: return 16'((mq.size() == 4 ? 1 : 0) + (mq.size() == 0 ? 2 : 0) +
                      (movf ? 4 : 0) + mq.size() * 8);
        default: return 16'h0;
      endcase
    end
    return 16'h0;
  endfunction

  // One clock: predict from pre-edge model state, advance, then compare
  task automatic step(input bit chk_on);
    int  ai;
    bit  pop;
    bit  was_full;
    bit  push_req;
    bit  clr;
    pop      = (mq.size() != 0) && tx_ready;
    was_full = (mq.size() == 4);
    push_req = 0;
    clr      = 0;
    ai       = int'(mem_addr);
    if (mem_rd) exp_rd = model_read(mem_addr);
    if (mem_wr) begin
      if (ai < 2 * RAM_WORDS) mram[ai / 2] = mem_wrdata;
      else if (ai >= 'hF000 && ai <= 'hF00F) begin
        case ((ai - 'hF000) / 2)
          0: mled = mem_wrdata;
          3: push_req = 1;
          4: clr = mem_wrdata[2];
          default: ;
        endcase
      end
    end
    if (clr) movf = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push_req) begin
      if (!was_full || pop) mq.push_back(mem_wrdata[7:0]);
      else movf = 1'b1;
    end
    mcycle = mcycle + 16'd1;
    swh.push_back(sw);
    void'(swh.pop_front());
    @(posedge clk);
    #1;
    if (chk_on) begin
      chk("rddata", mem_rddata, exp_rd);
      chk("led", led, mled);
      chk("tx_valid", {15'b0, tx_valid}, {15'b0, mq.size() != 0});
      chk("tx_data", {8'b0, tx_data}, {8'b0, (mq.size() != 0) ? mq[0] : 8'h00});
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    mem_rd     = rd;
    mem_wr     = wr;
    mem_addr   = a;
    mem_wrdata = d;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    drive(rd, wr, a, d);
    step(1);
  endtask

  logic [7:0]  exp_bytes [4];
  logic [15:0] ra;
  int          guard;

  initial begin
    reset = 1'b0;
    drive(0, 0, 16'h0, 16'h0);
    sw       = 16'h0;
    tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rddata", mem_rddata, 16'h0);
    chk("reset_led", led, 16'h0);
    chk("reset_tx_valid", {15'b0, tx_valid}, 16'h0);
    chk("reset_tx_data", {8'b0, tx_data}, 16'h0);

    @(negedge clk);
    reset = 1'b1;

    // CYCLE read 5 cycles after release returns 5
    repeat (5) op(0, 0, 16'h0, 16'h0);
    op(1, 0, 16'hF002, 16'h0);
    chk("cycle_n", mem_rddata, 16'd5);

    // Give every RAM word used below a known value
    for (int i = 0; i < 32; i++) op(0, 1, 16'(2 * i), 16'($urandom));
    op(0, 1, 16'h1FFE, 16'($urandom));

    // RAM write/read and read-before-write
    op(0, 1, 16'h0010, 16'hBEEF);
    op(1, 0, 16'h0010, 16'h0);
    chk("ram_beef_0010", mem_rddata, 16'hBEEF);
    op(1, 0, 16'h0011, 16'h0);
    chk("ram_beef_0011", mem_rddata, 16'hBEEF);
    op(1, 1, 16'h0010, 16'h1234);
    chk("ram_rbw_old", mem_rddata, 16'hBEEF);
    op(0, 0, 16'h0, 16'h0);
    chk("ram_hold", mem_rddata, 16'hBEEF);
    op(1, 0, 16'h0010, 16'h0);
    chk("ram_new", mem_rddata, 16'h1234);
    op(1, 0, 16'h1FFE, 16'h0);

    // MMIO map
    op(0, 1, 16'hF000, 16'h00A5);
    chk("led_a5", led, 16'h00A5);
    op(1, 0, 16'hF000, 16'h0);
    chk("led_read", mem_rddata, 16'h00A5);
    op(0, 1, 16'hF002, 16'hFFFF);
    op(1, 0, 16'hF002, 16'h0);
    op(1, 0, 16'h9000, 16'h0);
    chk("unmapped_9000", mem_rddata, 16'h0);
    op(1, 0, 16'h2000, 16'h0);
    chk("unmapped_2000", mem_rddata, 16'h0);
    op(1, 0, 16'hF006, 16'h0);
    chk("txdata_read", mem_rddata, 16'h0);

    // FIFO fill and overflow
    tx_ready = 1'b0;
    op(0, 1, 16'hF006, 16'h0011);
    op(0, 1, 16'hF006, 16'h0022);
    op(0, 1, 16'hF006, 16'h0033);
    op(0, 1, 16'hF006, 16'h0044);
    op(0, 1, 16'hF006, 16'h0055);
    chk("fifo_head", {8'b0, tx_data}, 16'h0011);
    op(1, 0, 16'hF008, 16'h0);
    chk("status_full_ovf", mem_rddata, 16'h0025);
    drive(0, 0, 16'h0, 16'h0);
    tx_ready = 1'b1;
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22;
    exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", {8'b0, tx_data}, {8'b0, exp_bytes[i]});
      step(1);
    end
    chk("drain_empty", {15'b0, tx_valid}, 16'h0);
    tx_ready = 1'b0;
    op(0, 1, 16'hF008, 16'h0004);
    op(1, 0, 16'hF008, 16'h0);
    chk("status_ovf_clr", mem_rddata, 16'h0002);

    // Full FIFO with simultaneous push and pop
    op(0, 1, 16'hF006, 16'h00A1);
    op(0, 1, 16'hF006, 16'h00A2);
    op(0, 1, 16'hF006, 16'h00A3);
    op(0, 1, 16'hF006, 16'h00A4);
    tx_ready = 1'b1;
    op(0, 1, 16'hF006, 16'h0066);
    tx_ready = 1'b0;
    op(1, 0, 16'hF008, 16'h0);
    chk("status_pushpop", mem_rddata, 16'h0021);
    drive(0, 0, 16'h0, 16'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("pushpop_fourth", {8'b0, tx_data}, 16'h0066);
      step(1);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    ra = 16'($urandom_range(0, 63));
        2:       ra = 16'h1FFE + 16'($urandom_range(0, 1));
        3, 4, 5: ra = 16'hF000 + 16'($urandom_range(0, 15));
        6:       ra = 16'h9000;
        default: ra = ($urandom_range(0, 1) != 0) ? 16'h2000 : 16'hF010;
      endcase
      sw       = 16'($urandom);
      tx_ready = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 9) < 4) op(0, 1, ra, 16'($urandom));
      else                          op(1, 0, ra, 16'h0);
    end

    // Async reset mid-drain with 3 entries queued
    drive(0, 0, 16'h0, 16'h0);
    tx_ready = 1'b1;
    guard = 0;
    while (mq.size() != 0 && guard < 10) begin
      step(1);
      guard++;
    end
    chk("pre_reset_drained", {15'b0, tx_valid}, 16'h0);
    tx_ready = 1'b0;
    op(0, 1, 16'h0010, 16'h1234);
    op(0, 1, 16'hF000, 16'h5A5A);
    for (int i = 0; i < 4; i++) op(0, 1, 16'hF006, 16'(8'hC0 + i));
    op(1, 0, 16'h0010, 16'h0);
    drive(0, 0, 16'h0, 16'h0);
    tx_ready = 1'b1;
    step(1);
    chk("pre_reset_valid", {15'b0, tx_valid}, 16'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rddata", mem_rddata, 16'h0);
    chk("async_led", led, 16'h0);
    chk("async_tx_valid", {15'b0, tx_valid}, 16'h0);
    chk("async_tx_data", {8'b0, tx_data}, 16'h0);
    model_reset();
    tx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    op(1, 0, 16'hF008, 16'h0);
    chk("post_reset_status", mem_rddata, 16'h0002);
    op(1, 0, 16'h0010, 16'h0);
    chk("post_reset_ram", mem_rddata, 16'h1234);

    // CYCLE wrap FFFF -> 0000
    drive(0, 0, 16'h0, 16'h0);
    guard = 0;
    while (mcycle != 16'hFFFE && guard < 70000) begin
      step(0);
      guard++;
    end
    op(1, 0, 16'hF002, 16'h0);
    chk("cycle_fffe", mem_rddata, 16'hFFFE);
    op(1, 0, 16'hF002, 16'h0);
    chk("cycle_ffff", mem_rddata, 16'hFFFF);
    op(1, 0, 16'hF002, 16'h0);
    chk("cycle_wrap", mem_rddata, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
